// File: rtl/ps2_host_tx_if.sv
// Host-side byte port of the PS/2 host transmitter: valid/ready request plus
// busy and one-cycle done/error completion status.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/odd
// parity/stop on device clock falls, then checks the device ACK bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic        clock,
  input  logic        resetn,
  ps2_host_tx_if.slave host,
  input  logic        ps2_clock_in,
  input  logic        ps2_data_in,
  output logic        ps2_clock_oe,
  output logic        ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, SEND, STOP, ACK, WAITIDLE, DONE, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             clock_oe_q, clock_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ready_q, busy_q, done_q, error_q;
  logic             clk_s1, clk_s2, clk_prev;
  logic             dat_s1, dat_s2;
  logic             fall;

  assign fall = clk_prev & ~clk_s2;

  // NOTE: reset is sampled on the clock edge like any other input, so it lives
  // inside the clocked block rather than in its sensitivity list.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_s1     <= 1'b0;
      clk_s2     <= 1'b0;
      clk_prev   <= 1'b0;
      dat_s1     <= 1'b0;
      dat_s2     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // which is what turns s1/s2/prev into a real shift chain.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      clock_oe_q <= clock_oe_d;
      data_oe_q  <= data_oe_d;
      ready_q    <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ERROR);
      clk_s1     <= ps2_clock_in;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      dat_s1     <= ps2_data_in;
      dat_s2     <= dat_s1;
    end
  end

  always_comb begin
    // NOTE: every signal assigned below gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    clock_oe_d = clock_oe_q;
    data_oe_d  = data_oe_q;

    case (state_q)
      IDLE: begin
        if (host.tx_valid && ready_q) begin
          shift_d    = {~^host.tx_data, host.tx_data};
          cnt_d      = '0;
          bitcnt_d   = '0;
          clock_oe_d = 1'b1;
          data_oe_d  = (INHIBIT_CYCLES == 1);
          state_d    = INHIBIT;
        end
      end

      // Start bit goes out one cycle before the clock is released.
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          clock_oe_d = 1'b0;
          cnt_d      = '0;
          bitcnt_d   = '0;
          state_d    = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((INHIBIT_CYCLES >= 2) && (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)))
            data_oe_d = 1'b1;
        end
      end

      SEND, STOP, ACK, WAITIDLE: begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
          case (state_q)
            SEND: if (fall) begin
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b0, shift_q[8:1]};
              bitcnt_d  = bitcnt_q + 1'b1;
              if (bitcnt_q == 4'd8) state_d = STOP;
            end
            STOP: if (fall) begin
              data_oe_d = 1'b0;
              state_d   = ACK;
            end
            ACK: if (fall) begin
              state_d = dat_s2 ? ERROR : WAITIDLE;
            end
            default: begin
              if (clk_s2 && dat_s2) state_d = DONE;
            end
          endcase
        end
      end

      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Any abort lets go of both lines in the same cycle the error pulse shows.
    if (state_d == ERROR) begin
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
    end
  end

  assign ps2_clock_oe  = clock_oe_q;
  assign ps2_data_oe   = data_oe_q;
  assign host.tx_ready = ready_q;
  assign host.busy     = busy_q;
  assign host.tx_done  = done_q;
  assign host.tx_error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain bus with a behavioural PS/2
// device that clocks frames, records bits on its rising edges and ACKs/NACKs.
module tb_ps2_host_tx;
  localparam int IC = 20;
  localparam int TO = 4000;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  ps2_host_tx_if hif();
  logic ps2_clock_in, ps2_data_in, ps2_clock_oe, ps2_data_oe;
  logic dev_clk_rel  = 1'b1;
  logic dev_data_rel = 1'b1;

  assign ps2_clock_in = ~ps2_clock_oe & dev_clk_rel;
  assign ps2_data_in  = ~ps2_data_oe  & dev_data_rel;

  ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TO)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .host         (hif),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the falling system-clock edge.
  int cyc = 0, oe_run = 0, last_oe_run = 0, rel_time = 0, err_time = 0;
  int done_cnt = 0, err_cnt = 0, hs_cnt = 0, hs_at_done = 0;
  logic oe_prev = 1'b0, pulse_prev = 1'b0, ready_after = 1'b0;
  logic [1:0] oe_at_err = 2'b00;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (ps2_clock_oe) oe_run++;
    else if (oe_prev) begin
      last_oe_run = oe_run;
      oe_run      = 0;
      rel_time    = cyc;
    end
    oe_prev = ps2_clock_oe;
    if (pulse_prev) ready_after = hif.tx_ready;
    pulse_prev = hif.tx_done | hif.tx_error;
    if (hif.tx_done) begin
      done_cnt++;
      hs_at_done = hs_cnt;
    end
    if (hif.tx_error) begin
      err_cnt++;
      err_time  = cyc;
      oe_at_err = {ps2_clock_oe, ps2_data_oe};
    end
    if (hif.tx_valid && hif.tx_ready) hs_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    hif.tx_data  = b;
    hif.tx_valid = 1'b1;
    for (int i = 0; i < 50 && !hif.tx_ready; i++) cycles(1);
    cycles(1);
    hif.tx_valid = 1'b0;
  endtask

  // Device side: the host's clock release is the first rising edge (start bit).
  logic [10:0] bits;
  bit          ok;

  task automatic dev_frame(input int ticks, input bit ack_phase, input bit ack);
    bits = '0;
    ok   = 1'b1;
    for (int i = 0; i < 100 && !ps2_clock_oe; i++) cycles(1);
    for (int i = 0; i < 200 && !ps2_clock_in; i++) cycles(1);
    if (!ps2_clock_in) begin
      ok = 1'b0;
      return;
    end
    bits[0] = ps2_data_in;
    cycles(20);
    for (int i = 1; i <= ticks; i++) begin
      dev_clk_rel = 1'b0;
      cycles(20);
      dev_clk_rel = 1'b1;
      bits[i] = ps2_data_in;
      cycles(20);
    end
    if (ack_phase) begin
      if (ack) dev_data_rel = 1'b0;
      cycles(5);
      dev_clk_rel = 1'b0;
      cycles(20);
      dev_clk_rel = 1'b1;
      cycles(5);
      dev_data_rel = 1'b1;
      cycles(2);
    end
  endtask

  task automatic wait_pulse(input int d0, input int e0, input int limit);
    for (int i = 0; i < limit && done_cnt == d0 && err_cnt == e0; i++) cycles(1);
    cycles(2);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic [10:0] exp_bits);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    dev_frame(10, 1'b1, 1'b1);
    check({tag, "_dev_saw_release"}, ok, 1);
    check({tag, "_bits"}, bits, exp_bits);
    wait_pulse(d0, e0, 300);
    check({tag, "_inhibit_len"}, last_oe_run, IC);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_error_count"}, err_cnt - e0, 0);
    check({tag, "_ready_after"}, ready_after, 1);
  endtask

  initial begin
    int d0, e0, h0;
    logic act;
    hif.tx_data  = 8'h00;
    hif.tx_valid = 1'b0;

    cycles(3);
    check("rst_ready", hif.tx_ready, 0);
    check("rst_busy", hif.busy, 0);
    check("rst_done", hif.tx_done, 0);
    check("rst_error", hif.tx_error, 0);
    check("rst_clock_oe", ps2_clock_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    resetn = 1'b1;
    cycles(1);
    check("ready_after_reset", hif.tx_ready, 1);

    // Device clocking while idle must leave the host untouched.
    d0  = done_cnt;
    e0  = err_cnt;
    act = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dev_data_rel = 1'b0;
      dev_clk_rel  = 1'b0;
      cycles(20);
      act = act | ps2_clock_oe | ps2_data_oe | hif.busy | ~hif.tx_ready;
      dev_clk_rel = 1'b1;
      cycles(20);
      act = act | ps2_clock_oe | ps2_data_oe | hif.busy | ~hif.tx_ready;
    end
    dev_data_rel = 1'b1;
    cycles(5);
    check("idle_traffic_ignored", act, 0);
    check("idle_traffic_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    // Bits are {stop, parity, data[7:0], start}.
    run_frame("ed", 8'hED, 11'b1_1_11101101_0);
    run_frame("x07", 8'h07, 11'b1_0_00000111_0);
    run_frame("x00", 8'h00, 11'b1_1_00000000_0);

    // NACK: data left high at the 11th fall.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hED);
    dev_frame(10, 1'b1, 1'b0);
    wait_pulse(d0, e0, 300);
    check("nack_error_count", err_cnt - e0, 1);
    check("nack_done_count", done_cnt - d0, 0);
    check("nack_oe_at_error", oe_at_err, 0);
    check("nack_ready_after", ready_after, 1);

    // Device never clocks after the release.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hED);
    wait_pulse(d0, e0, IC + TO + 200);
    check("tmo_error_count", err_cnt - e0, 1);
    check("tmo_done_count", done_cnt - d0, 0);
    check("tmo_latency", err_time - rel_time, TO);
    check("tmo_oe_at_error", oe_at_err, 0);
    check("tmo_ready_after", ready_after, 1);

    // Reset after the 4th data bit of 0x07 (d3 = 0, so data is being pulled).
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h07);
    dev_frame(4, 1'b0, 1'b0);
    check("mid_data_oe_before_reset", ps2_data_oe, 1);
    resetn = 1'b0;
    cycles(1);
    check("mid_rst_clock_oe", ps2_clock_oe, 0);
    check("mid_rst_data_oe", ps2_data_oe, 0);
    check("mid_rst_busy", hif.busy, 0);
    check("mid_rst_pulses", {hif.tx_done, hif.tx_error}, 0);
    resetn = 1'b1;
    cycles(1);
    check("mid_rst_ready", hif.tx_ready, 1);
    check("mid_rst_no_pulse_count", (done_cnt - d0) + (err_cnt - e0), 0);
    run_frame("xff", 8'hFF, 11'b1_1_11111111_0);

    // tx_valid held through a frame: one handshake per frame.
    h0 = hs_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    hif.tx_data  = 8'hF4;
    hif.tx_valid = 1'b1;
    for (int i = 0; i < 50 && hs_cnt == h0; i++) cycles(1);
    hif.tx_data = 8'h55;
    dev_frame(10, 1'b1, 1'b1);
    check("hold_a_bits", bits, 11'b1_0_11110100_0);
    wait_pulse(d0, e0, 300);
    check("hold_a_inhibit_len", last_oe_run, IC);
    check("hold_one_hs_per_frame", hs_at_done - h0, 1);
    for (int i = 0; i < 50 && hs_cnt == h0 + 1; i++) cycles(1);
    hif.tx_valid = 1'b0;
    d0 = done_cnt;
    dev_frame(10, 1'b1, 1'b1);
    check("hold_b_bits", bits, 11'b1_1_01010101_0);
    wait_pulse(d0, e0, 300);
    check("hold_b_inhibit_len", last_oe_run, IC);
    check("hold_b_done_count", done_cnt - d0, 1);
    check("hold_total_hs", hs_cnt - h0, 2);
    check("hold_error_count", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
